// File: rtl/sc_spi_sclkgen_if.sv
// ---------------------------------------------------------------------------
// sc_spi_sclkgen_if
//
// Purpose:
//   Bundles the configuration, control and status signals that pass between
//   the SPI protocol engine and the burst-mode serial clock generator. Only
//   the system clock and reset remain outside this interface.
//
// Signals:
//   CLK_CLKDR  [DIVW-1:0]  divide ratio D (0 and 1 behave as 2)
//   CLK_MODE   [1:0]       SPI mode, bit1 = CPOL, bit0 = CPHA
//   CLK_NBITS  [CNTW-1:0]  pulses per burst N (0 means 2^CNTW)
//   CLK_START              one-cycle burst request
//   CLK_STOP               abort request
//   SPICLK                 registered serial clock
//   LAUNCH                 one-cycle strobe: drive the next MOSI bit
//   SAMPLE                 one-cycle strobe: capture MISO
//   BUSY                   burst in progress
//   DONE                   one-cycle pulse on normal burst completion
//
// Modports:
//   master - the protocol engine side (drives config/control)
//   slave  - the clock generator side (drives SPICLK and strobes)
// ---------------------------------------------------------------------------
interface sc_spi_sclkgen_if #(
    parameter int DIVW = 8,
    parameter int CNTW = 6
);

    logic [DIVW-1:0] CLK_CLKDR;
    logic [1:0]      CLK_MODE;
    logic [CNTW-1:0] CLK_NBITS;
    logic            CLK_START;
    logic            CLK_STOP;

    logic            SPICLK;
    logic            LAUNCH;
    logic            SAMPLE;
    logic            BUSY;
    logic            DONE;

    modport master (
        output CLK_CLKDR,
        output CLK_MODE,
        output CLK_NBITS,
        output CLK_START,
        output CLK_STOP,
        input  SPICLK,
        input  LAUNCH,
        input  SAMPLE,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  CLK_CLKDR,
        input  CLK_MODE,
        input  CLK_NBITS,
        input  CLK_START,
        input  CLK_STOP,
        output SPICLK,
        output LAUNCH,
        output SAMPLE,
        output BUSY,
        output DONE
    );

endinterface

// File: rtl/sc_spi_sclkgen.sv
// ---------------------------------------------------------------------------
// sc_spi_sclkgen
//
// Purpose:
//   Burst-mode SPI serial clock generator. On an accepted start request it
//   latches the divide ratio, SPI mode and pulse count, then produces exactly
//   N SPICLK pulses with period D source clocks. For every pulse it raises a
//   one-cycle LAUNCH strobe on the edge where the shift register must drive
//   MOSI and a one-cycle SAMPLE strobe on the edge where MISO must be
//   captured, so the downstream shifter never needs its own edge detector.
//   DONE pulses for one cycle when a burst completes normally; an abort via
//   CLK_STOP returns to idle silently.
//
//   Each SPICLK pulse is a leading half of H1 = floor(D/2) cycles at ~CPOL
//   followed by a trailing half of H2 = D - H1 cycles at CPOL. A setup phase
//   of H2 cycles at CPOL precedes the first pulse, giving the MOSI line time
//   to settle before the first edge.
//
// Ports:
//   SRCCLK   system clock, all logic on its rising edge
//   SYSRSTB  asynchronous active-low reset
//   bus      slave side of sc_spi_sclkgen_if (config, control, SPICLK,
//            LAUNCH, SAMPLE, BUSY, DONE)
// ---------------------------------------------------------------------------
module sc_spi_sclkgen #(
    parameter int DIVW = 8,
    parameter int CNTW = 6
) (
    input  logic              SRCCLK,
    input  logic              SYSRSTB,
    sc_spi_sclkgen_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LEAD  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t          state_q, state_d;

    // Configuration captured at start; the burst runs from these copies.
    logic [DIVW-1:0] div_q, div_d;
    logic [1:0]      mode_q, mode_d;
    logic [CNTW-1:0] nbits_q, nbits_d;

    // Cycles spent in the current phase, starting at 1 on phase entry.
    logic [DIVW-1:0] half_cnt_q, half_cnt_d;

    // Completed pulses; one bit wider than N so a full 2^CNTW burst fits.
    logic [CNTW:0]   pulse_cnt_q, pulse_cnt_d;

    logic            spiclk_q, spiclk_d;
    logic            launch_q, launch_d;
    logic            sample_q, sample_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [DIVW-1:0] div_eff;
    logic [DIVW-1:0] half_lead;
    logic [DIVW-1:0] half_trail;
    logic [CNTW:0]   n_eff;
    logic [CNTW:0]   pulse_next;
    logic            last_pulse;
    logic            cpol;
    logic            cpha;

    // Derived burst geometry from the latched configuration. Ratios below
    // two cannot form a clock with both halves present, so they are raised
    // to two. A zero pulse count stands for the full 2^CNTW burst.
    always_comb begin
        div_eff    = (div_q < DIVW'(2)) ? DIVW'(2) : div_q;
        half_lead  = div_eff >> 1;
        half_trail = div_eff - half_lead;
        n_eff      = (nbits_q == '0) ? {1'b1, {CNTW{1'b0}}} : {1'b0, nbits_q};
        pulse_next = pulse_cnt_q + (CNTW+1)'(1);
        last_pulse = (pulse_next == n_eff);
        cpol       = mode_q[1];
        cpha       = mode_q[0];
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // and registered, so every strobe lines up with the SPICLK edge it marks.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        mode_d      = mode_q;
        nbits_d     = nbits_q;
        half_cnt_d  = half_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        spiclk_d    = spiclk_q;
        launch_d    = 1'b0;
        sample_d    = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Idle level tracks the live CPOL input with one cycle of lag.
                spiclk_d    = bus.CLK_MODE[1];
                busy_d      = 1'b0;
                half_cnt_d  = '0;
                pulse_cnt_d = '0;
                if (bus.CLK_START && !bus.CLK_STOP) begin
                    state_d    = SETUP;
                    div_d      = bus.CLK_CLKDR;
                    mode_d     = bus.CLK_MODE;
                    nbits_d    = bus.CLK_NBITS;
                    half_cnt_d = DIVW'(1);
                    busy_d     = 1'b1;
                    // With CPHA = 0 the first bit must be on MOSI before the
                    // first edge, so it is launched at the very start.
                    launch_d   = ~bus.CLK_MODE[0];
                end
            end

            SETUP: begin
                if (half_cnt_q == half_trail) begin
                    state_d    = LEAD;
                    half_cnt_d = DIVW'(1);
                    spiclk_d   = ~cpol;
                    sample_d   = ~cpha;
                    launch_d   = cpha;
                end else begin
                    half_cnt_d = half_cnt_q + DIVW'(1);
                end
            end

            LEAD: begin
                if (half_cnt_q == half_lead) begin
                    state_d    = TRAIL;
                    half_cnt_d = DIVW'(1);
                    spiclk_d   = cpol;
                    sample_d   = cpha;
                    // No bit follows the final pulse, so nothing to launch.
                    launch_d   = ~cpha & ~last_pulse;
                end else begin
                    half_cnt_d = half_cnt_q + DIVW'(1);
                end
            end

            TRAIL: begin
                if (half_cnt_q == half_trail) begin
                    pulse_cnt_d = pulse_next;
                    half_cnt_d  = DIVW'(1);
                    if (last_pulse) begin
                        state_d  = IDLE;
                        spiclk_d = cpol;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        state_d  = LEAD;
                        spiclk_d = ~cpol;
                        sample_d = ~cpha;
                        launch_d = cpha;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + DIVW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // An abort overrides whatever the burst would have done this cycle:
        // park at the latched idle level with no strobes and no DONE.
        if ((state_q != IDLE) && bus.CLK_STOP) begin
            state_d     = IDLE;
            half_cnt_d  = '0;
            pulse_cnt_d = '0;
            spiclk_d    = cpol;
            launch_d    = 1'b0;
            sample_d    = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge SRCCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_q     <= IDLE;
            div_q       <= '0;
            mode_q      <= '0;
            nbits_q     <= '0;
            half_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            spiclk_q    <= 1'b0;
            launch_q    <= 1'b0;
            sample_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            nbits_q     <= nbits_d;
            half_cnt_q  <= half_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            spiclk_q    <= spiclk_d;
            launch_q    <= launch_d;
            sample_q    <= sample_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.SPICLK = spiclk_q;
    assign bus.LAUNCH = launch_q;
    assign bus.SAMPLE = sample_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;

endmodule

// File: tb/tb_sc_spi_sclkgen.sv
// ---------------------------------------------------------------------------
// tb_sc_spi_sclkgen
//
// Purpose:
//   Self-checking bench for sc_spi_sclkgen. Cycle 0 is the cycle in which
//   CLK_START is held high; outputs of cycle t are sampled on the falling
//   edge inside cycle t and compared against a waveform model computed
//   directly from the burst timing rules (setup of H2 cycles, then N pulses
//   of D cycles, DONE one cycle after the last trailing half).
// ---------------------------------------------------------------------------
module tb_sc_spi_sclkgen;

    localparam int DIVW = 8;
    localparam int CNTW = 6;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    sc_spi_sclkgen_if #(.DIVW(DIVW), .CNTW(CNTW)) bus ();

    sc_spi_sclkgen #(.DIVW(DIVW), .CNTW(CNTW)) dut (
        .SRCCLK  (clk),
        .SYSRSTB (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packed view {SPICLK, LAUNCH, SAMPLE, BUSY, DONE}.
    function automatic logic [4:0] observed();
        return {bus.SPICLK, bus.LAUNCH, bus.SAMPLE, bus.BUSY, bus.DONE};
    endfunction

    function automatic int burstLength(int d, int n);
        int de, h2, ne;
        de = (d < 2) ? 2 : d;
        h2 = de - de / 2;
        ne = (n == 0) ? 64 : n;
        return h2 + ne * de;
    endfunction

    // Expected outputs in cycle t of a burst started at cycle 0.
    function automatic logic [4:0] modelAt(int t, int d, int m, int n);
        int  de, h1, h2, ne, total, k, p;
        bit  cpol, cpha, sclk, la, sa, bu, dn;
        de    = (d < 2) ? 2 : d;
        h1    = de / 2;
        h2    = de - h1;
        ne    = (n == 0) ? 64 : n;
        total = h2 + ne * de;
        cpol  = bit'((m >> 1) & 1);
        cpha  = bit'(m & 1);
        la = 1'b0; sa = 1'b0; dn = 1'b0;
        if (t <= h2) begin
            sclk = cpol;
            bu   = 1'b1;
            la   = (t == 1) && !cpha;
        end else if (t <= total) begin
            k  = (t - h2 - 1) / de;
            p  = (t - h2 - 1) % de;
            bu = 1'b1;
            if (p < h1) begin
                sclk = ~cpol;
                sa   = (p == 0) && !cpha;
                la   = (p == 0) && cpha;
            end else begin
                sclk = cpol;
                sa   = (p == h1) && cpha;
                la   = (p == h1) && !cpha && (k < ne - 1);
            end
        end else begin
            sclk = cpol;
            bu   = 1'b0;
            dn   = (t == total + 1);
        end
        return {sclk, la, sa, bu, dn};
    endfunction

    // Cycle in which the third SAMPLE strobe of a burst is expected.
    function automatic int thirdSample(int d, int m, int n);
        int cnt;
        logic [4:0] e;
        cnt = 0;
        for (int t = 1; t <= burstLength(d, n); t++) begin
            e = modelAt(t, d, m, n);
            if (e[2]) begin
                cnt++;
                if (cnt == 3) return t;
            end
        end
        return burstLength(d, n);
    endfunction

    // Run one burst. stopAt >= 1 aborts in that cycle; disturb changes the
    // config inputs and pulses CLK_START while the burst is running.
    task automatic applyStimulus(input int d, input int m, input int n,
                                 input int stopAt, input bit disturb);
        int total, last, launches, samples;
        logic [4:0] exp;
        bit cpol;
        total    = burstLength(d, n);
        last     = (stopAt > 0) ? stopAt + 3 : total + 1;
        cpol     = bit'((m >> 1) & 1);
        launches = 0;
        samples  = 0;
        @(negedge clk);
        bus.CLK_CLKDR = DIVW'(d);
        bus.CLK_MODE  = 2'(m);
        bus.CLK_NBITS = CNTW'(n);
        bus.CLK_START = 1'b1;
        bus.CLK_STOP  = 1'b0;
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            bus.CLK_START = 1'b0;
            bus.CLK_STOP  = 1'b0;
            if (stopAt > 0 && t > stopAt) exp = {cpol, 4'b0000};
            else                          exp = modelAt(t, d, m, n);
            checkOutput($sformatf("burst d=%0d m=%0d n=%0d stop=%0d t=%0d",
                                  d, m, n, stopAt, t), 32'(observed()), 32'(exp));
            if (bus.LAUNCH) launches++;
            if (bus.SAMPLE) samples++;
            if (t == stopAt) bus.CLK_STOP = 1'b1;
            if (disturb) begin
                if (t == 2) begin
                    bus.CLK_CLKDR = DIVW'($urandom_range(0, 20));
                    bus.CLK_MODE  = 2'($urandom_range(0, 3));
                end
                if (t == 4 && t < total) bus.CLK_START = 1'b1;
                if (t == total) begin
                    bus.CLK_CLKDR = DIVW'(d);
                    bus.CLK_MODE  = 2'(m);
                end
            end
        end
        bus.CLK_START = 1'b0;
        bus.CLK_STOP  = 1'b0;
        if (stopAt <= 0) begin
            checkOutput($sformatf("launch count d=%0d n=%0d", d, n),
                        32'(launches), 32'((n == 0) ? 64 : n));
            checkOutput($sformatf("sample count d=%0d n=%0d", d, n),
                        32'(samples), 32'((n == 0) ? 64 : n));
        end
        @(negedge clk);
        checkOutput($sformatf("idle after d=%0d m=%0d n=%0d", d, m, n),
                    32'(observed()), 32'({cpol, 4'b0000}));
    endtask

    // START and STOP together in idle must not begin a burst.
    task automatic collision(input int m);
        bit cpol;
        cpol = bit'((m >> 1) & 1);
        @(negedge clk);
        bus.CLK_CLKDR = DIVW'(4);
        bus.CLK_MODE  = 2'(m);
        bus.CLK_NBITS = CNTW'(4);
        bus.CLK_START = 1'b1;
        bus.CLK_STOP  = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            bus.CLK_START = 1'b0;
            bus.CLK_STOP  = 1'b0;
            checkOutput($sformatf("start+stop m=%0d t=%0d", m, t),
                        32'(observed()), 32'({cpol, 4'b0000}));
        end
    endtask

    initial begin
        int d, m, n, s;
        rst_n         = 1'b1;
        bus.CLK_CLKDR = '0;
        bus.CLK_MODE  = 2'b00;
        bus.CLK_NBITS = '0;
        bus.CLK_START = 1'b0;
        bus.CLK_STOP  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset state", 32'(observed()), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted in the middle of a D=4, N=8 burst.
        bus.CLK_CLKDR = DIVW'(4);
        bus.CLK_MODE  = 2'b00;
        bus.CLK_NBITS = CNTW'(8);
        bus.CLK_START = 1'b1;
        @(negedge clk);
        bus.CLK_START = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("busy before reset", 32'(bus.BUSY), 32'(1));
        #1 rst_n = 1'b0;
        #1 checkOutput("async reset mid-burst", 32'(observed()), 32'(0));
        bus.CLK_MODE = 2'b10;
        repeat (2) @(negedge clk);
        checkOutput("held in reset", 32'(observed()), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle cpol=1 after reset", 32'(observed()), 32'(5'b10000));
        repeat (3) @(negedge clk);
        checkOutput("no done after reset", 32'(observed()), 32'(5'b10000));

        // Directed bursts.
        applyStimulus(4, 0, 8, 0, 1'b0);
        applyStimulus(5, 3, 3, 0, 1'b0);
        applyStimulus(0, 0, 4, 0, 1'b0);
        applyStimulus(1, 1, 4, 0, 1'b0);
        applyStimulus(2, 2, 4, 0, 1'b0);
        applyStimulus(2, 0, 0, 0, 1'b0);
        applyStimulus(4, 1, 8, thirdSample(4, 1, 8), 1'b0);
        applyStimulus(4, 0, 8, thirdSample(4, 0, 8), 1'b0);
        applyStimulus(6, 2, 5, 0, 1'b1);
        collision(0);
        collision(2);

        // Randomized bursts, some disturbed, some aborted.
        for (int i = 0; i < 24; i++) begin
            d = $urandom_range(0, 12);
            m = $urandom_range(0, 3);
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
            if (n == 0) d = $urandom_range(0, 3);
            s = 0;
            if ($urandom_range(0, 3) == 0) s = $urandom_range(1, burstLength(d, n));
            applyStimulus(d, m, n, s, (s == 0) && ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_spi_sclkgen.md
Name: sc_spi_sclkgen

Overview:
Parametrised burst-mode SPI serial clock generator for the SPI protocol engine. It generates SPICLK in all four SPI modes (CPOL/CPHA) from SRCCLK with a programmable divide ratio. It emits exactly N clock pulses per burst, then signals completion. It also provides one-cycle LAUNCH/SAMPLE strobes aligned to SPICLK edges, so the shift register needs no edge detection.

Parameters:
DIVW, 8, width of divide-ratio input; SPICLK period = effective divide ratio in SRCCLK cycles
CNTW, 6, width of pulse-count input and internal pulse counter

Ports:
SRCCLK  in  1  system clock; all logic on rising edge
SYSRSTB  in  1  reset, asynchronous assert, active-low
CLK_CLKDR  in  DIVW  divide ratio D; values 0 and 1 are treated as 2
CLK_MODE  in  2  SPI mode; bit1 = CPOL, bit0 = CPHA
CLK_NBITS  in  CNTW  SPICLK pulses per burst N; 0 means 2^CNTW
CLK_START  in  1  one-cycle burst request
CLK_STOP  in  1  abort request
SPICLK  out  1  serial clock, registered
LAUNCH  out  1  one-cycle strobe: drive next MOSI bit
SAMPLE  out  1  one-cycle strobe: capture MISO
BUSY  out  1  burst in progress
DONE  out  1  one-cycle pulse at normal burst completion

Behaviour:
- Reset (SYSRSTB = 0, async): SPICLK = 0, LAUNCH = 0, SAMPLE = 0, BUSY = 0, DONE = 0; state IDLE; latched config cleared.
- Config latch:
  - CLK_CLKDR, CLK_MODE and CLK_NBITS are latched on the cycle CLK_START is accepted.
  - Changes to these inputs during a burst have no effect.
- Derived half-periods: H1 = floor(D/2), the leading half at ~CPOL. H2 = D - H1, the trailing half at CPOL. Odd D gives a longer trailing half.
- IDLE:
  - SPICLK = CLK_MODE[1], registered, so it follows with one cycle of lag.
  - BUSY = 0.
  - CLK_START = 1 and CLK_STOP = 0 -> go to SETUP next cycle; BUSY = 1.
- SETUP:
  - Lasts H2 cycles; SPICLK = CPOL.
  - If CPHA = 0, LAUNCH = 1 in the first SETUP cycle.
- LEAD:
  - Entry cycle toggles SPICLK to ~CPOL.
  - In that same cycle, SAMPLE = 1 if CPHA = 0, or LAUNCH = 1 if CPHA = 1.
  - Lasts H1 cycles, then go to TRAIL.
- TRAIL:
  - Entry cycle returns SPICLK to CPOL.
  - In that same cycle, SAMPLE = 1 if CPHA = 1.
  - If CPHA = 0, LAUNCH = 1 in that cycle, except on the final pulse.
  - Lasts H2 cycles. The pulse counter increments on TRAIL exit.
  - If the count is below N, go to LEAD; otherwise go to IDLE with DONE = 1 and BUSY = 0 in that same cycle.
- Burst length: START accepted at cycle 0 -> BUSY high for cycles 1 .. H2 + N*D; DONE in cycle H2 + N*D + 1.
- Strobe counts per burst: exactly N LAUNCH and N SAMPLE. LAUNCH and SAMPLE are never asserted in the same cycle.
- CLK_START while BUSY: ignored.
- CLK_STOP while BUSY:
  - Next cycle: IDLE, SPICLK = latched CPOL, BUSY = 0.
  - No DONE, no further strobes; the counter is cleared.
- CLK_START and CLK_STOP in the same cycle: STOP wins; the start is discarded.
- Counter widths:
  - Half-period counter is DIVW bits; pulse counter is CNTW+1 bits, so N = 2^CNTW cannot wrap.
  - All comparisons are unsigned.
- Async reset mid-burst: immediate return to reset values; no DONE.

Test Plan:
- Reset and idle: assert SYSRSTB = 0 mid-burst (D=4, N=8) -> outputs go to 0 immediately. After release with CLK_MODE = 2'b10, SPICLK = 1 one cycle later; BUSY = 0.
- Mode 0 (D=4, N=8, START at cycle 0):
  - BUSY high cycles 1-34; DONE only in cycle 35.
  - First LAUNCH at cycle 1; first SPICLK rise at cycle 3 with SAMPLE.
  - 8 SAMPLE, 8 LAUNCH; SPICLK period 4, high 2 cycles.
- Mode 3 (D=5, N=3):
  - SPICLK idles 1, low 2 cycles, high 3 cycles per pulse.
  - LAUNCH on each falling edge, SAMPLE on each rising edge; 3 each.
  - DONE at cycle 3 + 15 + 1 = 19.
- Degenerate config:
  - D = 0 and D = 1 behave identically to D = 2, toggling every cycle.
  - N = 0 with CNTW = 6 -> exactly 64 pulses, then DONE.
- Abort/collisions:
  - CLK_STOP asserted after the 3rd SAMPLE -> BUSY falls next cycle; SPICLK = CPOL; no DONE; no further strobes.
  - A CLK_START pulse mid-burst is ignored.
  - START+STOP in the same idle cycle -> no burst.
- Config stability: change CLK_CLKDR and CLK_MODE mid-burst -> period, polarity and strobe pattern unchanged until DONE; the new values apply on the next START.
